div_32_16_seq: RTL and testbench
================================

Name: div_32_16_seq

Overview:
- Sequential signed divider, the inverse operation of the 16x16 Booth/Wallace multiplier: 32-bit signed dividend ÷ 16-bit signed divisor.
- Outputs a 32-bit quotient and a 16-bit remainder.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock, with start/busy/done handshake.
- Used as a checker for multiplier products, and as the division unit beside mult_16_16_top in the arithmetic datapath.

Parameters:
- DIVIDEND_W, 32, dividend and quotient width; fixed at 2*DIVISOR_W.
- DIVISOR_W, 16, divisor and remainder width.

Ports:
- sys_clk  input  1  rising-edge clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A_NUM  input  32  signed dividend (two's complement).
- B_NUM  input  16  signed divisor (two's complement).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; Q_NUM/R_NUM/div_zero valid from this cycle.
- Q_NUM  output  32  signed quotient, truncated toward zero.
- R_NUM  output  16  signed remainder; sign follows the dividend.
- div_zero  output  1  divisor was zero for the completed operation.

Behaviour:
- Reset (async assert, sync deassert by the user): state=IDLE; busy=0, done=0, Q_NUM=0, R_NUM=0, div_zero=0. Asserting reset mid-operation aborts it; no done is issued.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1 at edge E0:
  - Capture |A_NUM| (33-bit-safe; 0x8000_0000 gives magnitude 2^31), |B_NUM| (0x8000 gives 2^15) and both sign bits.
  - Record div_zero_pending = (B_NUM==0). Clear the iteration counter. Go to CALC.
  - busy=1 from E0.
- CALC, 32 cycles (counter 0..31):
  - Each edge: partial remainder (17 bits) = {rem[15:0], dividend_msb}; shift the dividend left.
  - If partial ≥ |divisor|, subtract and shift in quotient bit 1; else shift in 0.
  - At counter=31, go to FIX.
- FIX, 1 cycle:
  - Quotient negated if sign(A) XOR sign(B); remainder negated if sign(A).
  - If div_zero_pending: Q=32'hFFFF_FFFF, R=A_NUM[15:0] as captured, div_zero=1.
  - Load Q_NUM/R_NUM/div_zero registers. Go to DONE.
- DONE: done=1, busy=0 for this single cycle. Go to IDLE.
- Latency: done high in the cycle following edge E0+34. The next start is accepted the earliest in the cycle after done (back-to-back throughput 35 clocks). Divide-by-zero uses the same latency.
- Overflow case 0x8000_0000 ÷ 0xFFFF: Q=0x8000_0000 (wraps), R=0, div_zero=0.
- Divisor magnitude 0x8000: handled via the 17-bit compare; no special case.
- start while busy or in DONE: ignored, no queuing.
- A_NUM/B_NUM may change after E0 without affecting the result.
- Q_NUM/R_NUM/div_zero hold their values until the next FIX load.
- Width rules: all arithmetic is unsigned on magnitudes; two's-complement negate = ~x+1 at the stated width.

Decomposition:
- Shared package div_pkg holds:
  - DIVIDEND_W/DIVISOR_W constants;
  - the state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3);
  - ITER_CNT_W=5;
  - DIV0_QUOT=32'hFFFF_FFFF.
- One natural sub-module: twos_abs (parameterised width). Outputs the magnitude and sign of a two's-complement value, and has a negate mode for the FIX stage. Instantiated for dividend, divisor, and result correction.

Test Plan:
- A=0x139D_FF24, B=0x5E81, start pulse -> done exactly 35 cycles after the start edge; Q=0x0000_3524, R=0x0000, div_zero=0; busy high for 34 cycles.
- Signs: A=-7, B=2 -> Q=0xFFFF_FFFD, R=0xFFFF. A=7, B=-2 -> Q=0xFFFF_FFFD, R=0x0001. A=-7, B=-2 -> Q=0x0000_0003, R=0xFFFF.
- A=0x0000_0064, B=0 -> same latency; Q=0xFFFF_FFFF, R=0x0064, div_zero=1. The next op A=100, B=10 -> div_zero=0, Q=10, R=0.
- A=0x8000_0000, B=0xFFFF -> Q=0x8000_0000, R=0. A=0x8000_0000, B=0x8000 -> Q=0x0001_0000, R=0.
- Extra start pulse in CALC with different operands -> ignored; the first result completes unchanged. sys_rst_n low at CALC cycle 10 -> all outputs 0, no done; a new op after release completes correctly.
- 1000 random signed A/B pairs with B≠0 -> checked against the model: A == Q*B + R, |R|<|B|, sign(R) equals sign(A) or R=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the 32/16 sequential signed divider.
package div_pkg;

  localparam int DIVISOR_W  = 16;
  localparam int DIVIDEND_W = 2 * DIVISOR_W;
  localparam int ITER_CNT_W = 5;

  // FSM encoding kept as plain 2-bit constants for compatibility with older tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Quotient reported when the divisor is zero.
  localparam logic [DIVIDEND_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Counter value of the final restoring iteration.
  localparam logic [ITER_CNT_W-1:0] LAST_ITER = 5'd31;

endpackage

// File: rtl/div_32_16_seq_twos_abs.sv
// Two's-complement magnitude / conditional negate unit.
// abs mode (neg_mode_i=0): negate when the input is negative, giving |val_i|.
// negate mode (neg_mode_i=1): negate when neg_req_i is set (sign correction).
// The most negative input yields 2^(W-1), which is exact as an unsigned W-bit value.
module twos_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_mode_i,
  input  logic         neg_req_i,
  output logic [W-1:0] mag_o,
  output logic         sign_o
);

  logic do_neg;

  // Select the negate condition and apply ~x+1 at width W.
  always_comb begin
    sign_o = val_i[W-1];
    do_neg = neg_mode_i ? neg_req_i : val_i[W-1];
    mag_o  = do_neg ? (~val_i + W'(1)) : val_i;
  end

endmodule

// File: rtl/div_32_16_seq.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor, radix-2
// restoring on magnitudes, one quotient bit per clock, then sign fix-up.
module div_32_16_seq
  import div_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] A_NUM,
  input  logic [DIVISOR_W-1:0]  B_NUM,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] Q_NUM,
  output logic [DIVISOR_W-1:0]  R_NUM,
  output logic                  div_zero
);

  logic [1:0]            state_q, state_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic [DIVISOR_W-1:0]  a_lo_q, a_lo_d;
  logic                  div0_pend_q, div0_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] q_num_q, q_num_d;
  logic [DIVISOR_W-1:0]  r_num_q, r_num_d;
  logic                  div_zero_q, div_zero_d;

  // The two sign units are shared: operand magnitudes in IDLE, result correction in FIX.
  logic                  in_fix;
  logic [DIVIDEND_W-1:0] abs_a_in, abs_a_out;
  logic [DIVISOR_W-1:0]  abs_b_in, abs_b_out;
  logic                  abs_a_sign, abs_b_sign;

  logic [DIVISOR_W:0]    partial;
  logic                  ge;

  // Route operands or results into the shared sign units.
  always_comb begin
    in_fix   = (state_q == ST_FIX);
    abs_a_in = in_fix ? dvd_q : A_NUM;
    abs_b_in = in_fix ? rem_q : B_NUM;
  end

  twos_abs #(.W(DIVIDEND_W)) u_abs_a (
    .val_i      (abs_a_in),
    .neg_mode_i (in_fix),
    .neg_req_i  (sign_a_q ^ sign_b_q),
    .mag_o      (abs_a_out),
    .sign_o     (abs_a_sign)
  );

  twos_abs #(.W(DIVISOR_W)) u_abs_b (
    .val_i      (abs_b_in),
    .neg_mode_i (in_fix),
    .neg_req_i  (sign_a_q),
    .mag_o      (abs_b_out),
    .sign_o     (abs_b_sign)
  );

  // One restoring step: 17-bit compare covers a divisor magnitude of 2^15.
  always_comb begin
    partial = {rem_q, dvd_q[DIVIDEND_W-1]};
    ge      = (partial >= {1'b0, dsr_q});
  end

  // Next-state and datapath control for IDLE -> CALC -> FIX -> DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    dsr_d       = dsr_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    a_lo_d      = a_lo_q;
    div0_pend_d = div0_pend_q;
    busy_d      = busy_q;
    // done is the registered image of the DONE state, so it lands one cycle later.
    done_d      = (state_q == ST_DONE);
    q_num_d     = q_num_q;
    r_num_d     = r_num_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d       = abs_a_out;
          dsr_d       = abs_b_out;
          rem_d       = '0;
          sign_a_d    = abs_a_sign;
          sign_b_d    = abs_b_sign;
          a_lo_d      = A_NUM[DIVISOR_W-1:0];
          div0_pend_d = (B_NUM == '0);
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_CALC;
        end
      end
      ST_CALC: begin
        // Low bits of the difference are exact because the result is < divisor.
        rem_d = ge ? (partial[DIVISOR_W-1:0] - dsr_q) : partial[DIVISOR_W-1:0];
        dvd_d = {dvd_q[DIVIDEND_W-2:0], ge};
        cnt_d = cnt_q + ITER_CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        q_num_d    = div0_pend_q ? DIV0_QUOT : abs_a_out;
        r_num_d    = div0_pend_q ? a_lo_q : abs_b_out;
        div_zero_d = div0_pend_q;
        state_d    = ST_DONE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      a_lo_q      <= '0;
      div0_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      q_num_q     <= '0;
      r_num_q     <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      dsr_q       <= dsr_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      a_lo_q      <= a_lo_d;
      div0_pend_q <= div0_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      q_num_q     <= q_num_d;
      r_num_q     <= r_num_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Q_NUM    = q_num_q;
  assign R_NUM    = r_num_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_32_16_seq.sv
// Directed and random checks for div_32_16_seq.
module tb_div_32_16_seq;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [31:0] A_NUM;
  logic [15:0] B_NUM;
  logic        busy;
  logic        done;
  logic [31:0] Q_NUM;
  logic [15:0] R_NUM;
  logic        div_zero;

  int checks;
  int failures;

  div_32_16_seq dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .A_NUM     (A_NUM),
    .B_NUM     (B_NUM),
    .busy      (busy),
    .done      (done),
    .Q_NUM     (Q_NUM),
    .R_NUM     (R_NUM),
    .div_zero  (div_zero)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble them to prove they were captured.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    @(negedge sys_clk);
    A_NUM = a;
    B_NUM = b;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    A_NUM = 32'hDEAD_BEEF;
    B_NUM = 16'h0000;
  endtask

  // lat = number of cycles after the start edge at which done is seen (0 = timeout).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge sys_clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] eq, input logic [15:0] er, input logic edz);
    int lat;
    int bcnt;
    start_op(a, b);
    wait_done(lat, bcnt);
    $display("op %s a=%h b=%h q=%h r=%h dz=%0d lat=%0d", tag, a, b, Q_NUM, R_NUM, div_zero, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd35);
    chk({tag, "_q"}, Q_NUM, eq);
    chk({tag, "_r"}, {16'h0, R_NUM}, {16'h0, er});
    chk({tag, "_dz"}, {31'h0, div_zero}, {31'h0, edz});
  endtask

  initial begin
    int lat;
    int bcnt;
    int dseen;
    logic [31:0] a;
    logic [15:0] b;
    longint la, lb, lq, lr;
    logic [63:0] prod;
    logic ok;

    checks    = 0;
    failures  = 0;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    A_NUM     = '0;
    B_NUM     = '0;

    repeat (3) @(negedge sys_clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_q", Q_NUM, 32'h0);
    chk("rst_r", {16'h0, R_NUM}, 32'h0);
    chk("rst_dz", {31'h0, div_zero}, 32'h0);
    sys_rst_n = 1'b1;

    // Basic operation with latency and busy-width checks.
    start_op(32'h139D_FF24, 16'h5E81);
    wait_done(lat, bcnt);
    $display("op basic a=139dff24 b=5e81 q=%h r=%h dz=%0d lat=%0d busy=%0d", Q_NUM, R_NUM, div_zero, lat, bcnt);
    chk("basic_lat", 32'(lat), 32'd35);
    chk("basic_busy", 32'(bcnt), 32'd34);
    chk("basic_q", Q_NUM, 32'h0000_3524);
    chk("basic_r", {16'h0, R_NUM}, 32'h0);
    chk("basic_dz", {31'h0, div_zero}, 32'h0);
    chk("basic_busy_at_done", {31'h0, busy}, 32'h0);
    @(negedge sys_clk);
    chk("basic_done_pulse", {31'h0, done}, 32'h0);
    chk("basic_q_hold", Q_NUM, 32'h0000_3524);

    // Sign combinations.
    do_div("neg_pos", 32'hFFFF_FFF9, 16'h0002, 32'hFFFF_FFFD, 16'hFFFF, 1'b0);
    do_div("pos_neg", 32'h0000_0007, 16'hFFFE, 32'hFFFF_FFFD, 16'h0001, 1'b0);
    do_div("neg_neg", 32'hFFFF_FFF9, 16'hFFFE, 32'h0000_0003, 16'hFFFF, 1'b0);

    // Divide by zero, then a normal op clears the flag.
    do_div("div0", 32'h0000_0064, 16'h0000, 32'hFFFF_FFFF, 16'h0064, 1'b1);
    do_div("after0", 32'd100, 16'd10, 32'd10, 16'd0, 1'b0);

    // Most-negative operands.
    do_div("ovf", 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0000, 1'b0);
    do_div("minb", 32'h8000_0000, 16'h8000, 32'h0001_0000, 16'h0000, 1'b0);

    // A second start during CALC must be ignored.
    start_op(32'd1000, 16'd7);
    repeat (5) @(negedge sys_clk);
    A_NUM = 32'd5;
    B_NUM = 16'd1;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    $display("op ignore a=1000 b=7 q=%h r=%h lat=%0d", Q_NUM, R_NUM, lat);
    chk("ign_seen", {31'h0, (lat != 0)}, 32'h1);
    chk("ign_q", Q_NUM, 32'd142);
    chk("ign_r", {16'h0, R_NUM}, 32'd6);
    dseen = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (done) dseen++;
    end
    chk("ign_no_second_done", 32'(dseen), 32'd0);

    // Reset in the middle of CALC aborts the operation.
    start_op(32'd12345, 16'd3);
    repeat (9) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    $display("op reset_mid busy=%0d done=%0d q=%h r=%h dz=%0d", busy, done, Q_NUM, R_NUM, div_zero);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_q", Q_NUM, 32'h0);
    chk("mid_r", {16'h0, R_NUM}, 32'h0);
    chk("mid_dz", {31'h0, div_zero}, 32'h0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    dseen = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (done) dseen++;
    end
    chk("mid_no_done", 32'(dseen), 32'd0);
    do_div("post_rst", 32'd12345, 16'd3, 32'd4115, 16'd0, 1'b0);

    // Random signed operands with a nonzero divisor.
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = 16'($urandom_range(1, 65535));
      start_op(a, b);
      wait_done(lat, bcnt);
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = longint'($signed(Q_NUM));
      lr = longint'($signed(R_NUM));
      prod = 64'(lq * lb + lr);
      ok = (lat == 35) && (div_zero == 1'b0)
           && (prod[31:0] == a)
           && (((lr < 0) ? -lr : lr) < ((lb < 0) ? -lb : lb))
           && ((lr == 0) || ((lr < 0) == (la < 0)))
           && (Q_NUM == 32'(la / lb)) && (R_NUM == 16'(la % lb));
      $display("op rnd%0d a=%h b=%h q=%h r=%h ok=%0d", n, a, b, Q_NUM, R_NUM, ok);
      chk("rnd", {31'h0, ok}, 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
